immediate_gen: RTL and testbench



---
 rtl/immediate_gen.sv | 139 +++++++++++++
 tb/tb_immediate_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/immediate_gen.sv
// immediate_gen: registered RV32I immediate generator for the decode stage.
//
// Decodes the instruction format from the opcode (and funct3 for shift-immediates),
// builds the extended 32-bit immediate and a format tag, and registers both so the
// ALU operand mux and branch-target adder see them one cycle after the instruction.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   instr        in  32   instruction word
//   instr_valid  in   1   instr is meaningful this cycle; capture enable for imm_ext/imm_type
//   imm_ext      out 32   registered extended immediate
//   imm_type     out  3   registered format tag (0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 I_SHAMT)
//   imm_valid    out  1   registered copy of instr_valid
module immediate_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic [31:0] imm_ext,
    output logic [2:0]  imm_type,
    output logic        imm_valid
);

    // Format tags; encoding is visible on imm_type so values are pinned.
    typedef enum logic [2:0] {
        ImmNone   = 3'd0,
        ImmI      = 3'd1,
        ImmS      = 3'd2,
        ImmB      = 3'd3,
        ImmU      = 3'd4,
        ImmJ      = 3'd5,
        ImmIShamt = 3'd6
    } imm_type_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] F3Sll = 3'b001;
    localparam logic [2:0] F3Srx = 3'b101;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sign;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign sign   = instr[31];

    // Candidate immediates for every format; the decoder below just picks one.
    logic [31:0] imm_i;
    logic [31:0] imm_shamt;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i     = {{20{sign}}, instr[31:20]};
    // Shift amount is zero-extended; funct7 (instr[31:25]) is deliberately ignored.
    assign imm_shamt = {27'b0, instr[24:20]};
    assign imm_s     = {{20{sign}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    imm_type_e   type_dec;
    logic [31:0] imm_dec;

    always_comb begin
        type_dec = ImmNone;
        unique case (opcode)
            OpLoad, OpJalr: type_dec = ImmI;
            OpOpImm: begin
                if (funct3 == F3Sll || funct3 == F3Srx) begin
                    type_dec = ImmIShamt;
                end else begin
                    type_dec = ImmI;
                end
            end
            OpStore:       type_dec = ImmS;
            OpBranch:      type_dec = ImmB;
            OpLui, OpAuipc: type_dec = ImmU;
            OpJal:         type_dec = ImmJ;
            default:       type_dec = ImmNone;
        endcase
    end

    always_comb begin
        imm_dec = 32'b0;
        unique case (type_dec)
            ImmI:      imm_dec = imm_i;
            ImmIShamt: imm_dec = imm_shamt;
            ImmS:      imm_dec = imm_s;
            ImmB:      imm_dec = imm_b;
            ImmU:      imm_dec = imm_u;
            ImmJ:      imm_dec = imm_j;
            default:   imm_dec = 32'b0;
        endcase
    end

    // Output registers: immediate and tag only load on a valid instruction, so a
    // bubble leaves the last result in place; the valid flag tracks every edge.
    logic [31:0] imm_q, imm_d;
    imm_type_e   type_q, type_d;
    logic        valid_q, valid_d;

    always_comb begin
        imm_d   = imm_q;
        type_d  = type_q;
        valid_d = instr_valid;
        if (instr_valid) begin
            imm_d  = imm_dec;
            type_d = type_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q   <= 32'b0;
            type_q  <= ImmNone;
            valid_q <= 1'b0;
        end else begin
            imm_q   <= imm_d;
            type_q  <= type_d;
            valid_q <= valid_d;
        end
    end

    assign imm_ext   = imm_q;
    assign imm_type  = type_q;
    assign imm_valid = valid_q;

endmodule

// File: tb/tb_immediate_gen.sv
module tb_immediate_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] imm_ext;
    logic [2:0]  imm_type;
    logic        imm_valid;

    immediate_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .imm_ext     (imm_ext),
        .imm_type    (imm_type),
        .imm_valid   (imm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  typ;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_last;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    // Scoreboard monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (imm_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got imm 0x%08h type %0d want no result",
                             imm_ext, imm_type);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_imm"}, imm_ext, e.imm);
                    check({e.name, "_type"}, {29'b0, imm_type}, {29'b0, e.typ});
                    exp_last = e;
                end
            end else begin
                check("hold_imm", imm_ext, exp_last.imm);
                check("hold_type", {29'b0, imm_type}, {29'b0, exp_last.typ});
                check("hold_valid", {31'b0, imm_valid}, 32'd0);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [31:0] imm, input logic [2:0] typ,
                        input string name);
        exp_t e;
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        e.imm  = imm;
        e.typ  = typ;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr       = $urandom;
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_imm"}, imm_ext, 32'd0);
        check({name, "_type"}, {29'b0, imm_type}, 32'd0);
        check({name, "_valid"}, {31'b0, imm_valid}, 32'd0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_last.imm  = 32'd0;
        exp_last.typ  = 3'd0;
        exp_last.name = "reset";
        #1;
        check_zero(name);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        exp_last.imm  = 32'd0;
        exp_last.typ  = 3'd0;
        exp_last.name = "reset";
        #3;
        check_zero("reset_initial");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed vectors, expected values computed by hand from the encodings.
        send(32'hfff10093, 32'hffffffff, 3'd1, "addi_m1");
        send(32'h00a02503, 32'h0000000a, 3'd1, "lw");
        send(32'h01f09093, 32'h0000001f, 3'd6, "slli");
        send(32'h4030d093, 32'h00000003, 3'd6, "srai");
        send(32'hfff09093, 32'h0000001f, 3'd6, "slli_funct7_junk");
        send(32'h00552223, 32'h00000004, 3'd2, "sw_pos");
        send(32'hfe552ca3, 32'hfffffff9, 3'd2, "sb_neg");
        send(32'hfe208ee3, 32'hfffffffc, 3'd3, "beq_neg");
        send(32'h00208463, 32'h00000008, 3'd3, "beq_pos");
        send(32'h12345537, 32'h12345000, 3'd4, "lui");
        send(32'hfffff097, 32'hfffff000, 3'd4, "auipc");
        send(32'h0010006f, 32'h00000800, 3'd5, "jal_pos");
        send(32'hffdff06f, 32'hfffffffc, 3'd5, "jal_neg");
        send(32'hffc08067, 32'hfffffffc, 3'd1, "jalr");
        send(32'h002081b3, 32'h00000000, 3'd0, "rtype");
        send(32'h0000000f, 32'h00000000, 3'd0, "fence");

        // Bubble after a NONE result, then a non-zero result to hold against.
        idle(1);
        send(32'h00a02503, 32'h0000000a, 3'd1, "lw_again");
        idle(3);

        // Four back-to-back, then drop valid with garbage instr: outputs hold.
        send(32'h01f09093, 32'h0000001f, 3'd6, "stream0");
        send(32'hfe552ca3, 32'hfffffff9, 3'd2, "stream1");
        send(32'h00208463, 32'h00000008, 3'd3, "stream2");
        send(32'h12345537, 32'h12345000, 3'd4, "stream3");
        idle(3);

        // Mid-stream asynchronous reset.
        send(32'hfe208ee3, 32'hfffffffc, 3'd3, "pre_reset0");
        send(32'h0010006f, 32'h00000800, 3'd5, "pre_reset1");
        async_reset("reset_mid");
        send(32'hfff10093, 32'hffffffff, 3'd1, "post_reset");
        idle(3);

        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
